lane_sprite_scheduler: RTL and testbench
========================================

Name: lane_sprite_scheduler

Overview:
- Per-frame game-state controller for the 4-lane plant/bullet/zombie playfield.
- Once per video frame it sequences bullet firing and motion, zombie spawning and motion, collision, scoring and game-over.
- It drives the position and active flags consumed by the VGA pixel-address generator.
- Lanes are processed one per clock, so a single shared move/collide datapath serves all four lanes.

Parameters:
- BULLET_STEP, 4: pixels a bullet advances per frame.
- ZOMBIE_STEP, 2: pixels a zombie advances per move frame.
- ZOMBIE_DIV, 1: zombies move on every ZOMBIE_DIV-th frame.
- FIRE_PERIOD, 32: frames between fire opportunities for a planted lane.
- ZOMBIE_HP, 3: bullet hits needed to kill a zombie.
- SPAWN_THRESH, 1: random spawn when lfsr[2:0] < SPAWN_THRESH; 0 disables random spawn.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vblank).
- restart  in  1  synchronous clear of all game state.
- plant_en  in  4  bit i = plant present in lane i.
- spawn_req  in  4  bit i forces a zombie spawn in lane i at its next lane slot.
- bullet_pos  out  44  lane i = bits [11i+10:11i]; bullet x-offset from 120.
- bullet_act  out  4  bullet i visible.
- zomb_pos  out  44  lane i packed as bullet_pos; zombie leftward offset from 520.
- zomb_act  out  4  zombie i visible.
- score  out  8  kills, saturating at 255.
- game_over  out  1  sticky.
- busy  out  1  high while lanes are being updated.
- update_done  out  1  one-cycle pulse when the frame update completes.

Behaviour:
- Reset: every output is 0. State is IDLE. LFSR = 8'hA5. fire_cnt = 0, zdiv_cnt = 0. Per-lane hp = 0.
- FSM states: IDLE, LANE (lane_idx 0..3), DONE.
- IDLE -> LANE (lane_idx = 0) on frame_tick && !game_over.
- LANE: one cycle per lane; after lane_idx 3 -> DONE.
- DONE -> IDLE after one cycle.
- busy = (state != IDLE).
- frame_tick while busy or game_over is ignored and not queued.
- Latency: frame_tick at cycle T -> lane 0 at T+1 ... lane 3 at T+4, DONE at T+5. update_done pulses at T+5. All outputs are final from T+6.
- LANE cycle for lane i, evaluated in this order using registered values:
  1. Spawn: if !zomb_act[i] && (spawn_req[i] || lfsr[2:0] < SPAWN_THRESH), then zomb_act = 1, zomb_pos = 0, hp = ZOMBIE_HP. The zombie does not move this frame.
  2. Fire: if plant_en[i] && !bullet_act[i] && fire_cnt == 0, then bullet_act = 1, bullet_pos = 0. The bullet does not move this frame.
  3. Move: otherwise an active bullet gets nb = pos + BULLET_STEP. An active zombie gets nz = gpos + ZOMBIE_STEP when zdiv_cnt == 0.
  4. Collision: both active and nb + nz >= 381, i.e. bullet right edge 139+pos reaches zombie left edge 520-gpos. The bullet clears (act 0, pos 0) and hp decrements. If hp reaches 0, the zombie clears and score increments (saturating). Collision takes priority over the off-screen clear.
  5. Off-screen: nb >= 520 clears the bullet.
  6. House: nz >= 520 sets zomb_pos = 520 and sets game_over. Remaining lanes of that frame still complete.
  7. The LFSR advances once per LANE cycle. Polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
- DONE:
  - fire_cnt = (fire_cnt == FIRE_PERIOD-1) ? 0 : fire_cnt + 1.
  - zdiv_cnt is updated likewise modulo ZOMBIE_DIV.
- Widths: all position arithmetic is 11 bits unsigned. Sums are at most 520 + step, so nothing wraps.
- restart has the highest priority and is honoured in any state, including mid-LANE. On the next edge all state and outputs return to reset values except the LFSR, which keeps running. game_over clears.
- spawn_req is sampled only during its own lane's slot.

Decomposition:
- Shared package: LANES = 4, BULLET_X0 = 120, ZOMBIE_X0 = 520, COLLIDE_SUM = 381, EDGE_MAX = 520, POS_W = 11, FSM state encoding.
- One sub-module: lfsr8 (enable, async reset to 8'hA5, 8-bit state out).
- The per-lane datapath is a single shared block muxed by lane_idx.

Test Plan:
- Reset/idle: assert rst mid-sim -> all outputs 0. A frame_tick with plant_en = 0 and SPAWN_THRESH = 0 -> busy high for cycles T+1..T+5, update_done at T+5, positions unchanged.
- Bullet travel: plant_en = 4'b0001, no zombies, FIRE_PERIOD = 32.
  - Frame 1 fires: act[0] = 1, pos = 0.
  - After 130 further frames, pos = 520 -> bullet cleared.
  - Refire only on a frame where fire_cnt == 0.
- Collision: spawn_req[0] and plant_en[0] on the same frame, ZOMBIE_DIV = 1.
  - 64 frames later nb = 256, nz = 128, sum 384 -> bullet cleared, hp 3 -> 2, zombie remains, score = 0.
  - A third hit kills: zomb_act[0] = 0, score = 1.
- Game over: spawn_req[2], no plants.
  - The 260th move frame gives nz = 520 -> zomb_pos lane 2 = 520 and game_over = 1.
  - Later frame_ticks produce no busy.
- Restart mid-update: pulse restart at T+2 -> next cycle state IDLE, busy = 0, all outputs 0, game_over = 0, and update_done is not pulsed.
- Busy overlap: frame_tick at T and T+3 -> only one update (single update_done). Score saturation: preload 255 by repeated kills -> stays at 255.

Source files
------------

// File: rtl/lane_sprite_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the lane sprite scheduler.
// Screen geometry is expressed as offsets from the bullet and zombie origins.
package lane_sprite_scheduler_pkg;

  localparam int LANES = 4;
  localparam int POS_W = 11;

  localparam logic [POS_W-1:0] BULLET_X0 = 11'd120;
  localparam logic [POS_W-1:0] ZOMBIE_X0 = 11'd520;
  localparam logic [POS_W-1:0] SPRITE_W  = 11'd19;
  // Bullet right edge (BULLET_X0 + SPRITE_W + nb) meets zombie left edge (ZOMBIE_X0 - nz).
  localparam logic [POS_W-1:0] COLLIDE_SUM = ZOMBIE_X0 - BULLET_X0 - SPRITE_W;
  localparam logic [POS_W-1:0] EDGE_MAX    = 11'd520;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LANE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lane_sprite_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
module lane_sprite_scheduler_lfsr8
  import lane_sprite_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] lfsr_r;

  // Shift register; advances only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else if (en) begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/lane_sprite_scheduler.sv
// Per-frame game-state controller: walks the four lanes one per clock through a
// single shared spawn/fire/move/collide datapath, then advances the frame counters.
module lane_sprite_scheduler
  import lane_sprite_scheduler_pkg::*;
#(
  parameter int BULLET_STEP  = 4,
  parameter int ZOMBIE_STEP  = 2,
  parameter int ZOMBIE_DIV   = 1,
  parameter int FIRE_PERIOD  = 32,
  parameter int ZOMBIE_HP    = 3,
  parameter int SPAWN_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic [3:0]  plant_en,
  input  logic [3:0]  spawn_req,
  output logic [43:0] bullet_pos,
  output logic [3:0]  bullet_act,
  output logic [43:0] zomb_pos,
  output logic [3:0]  zomb_act,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        busy,
  output logic        update_done
);

  localparam int FW  = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam int ZW  = (ZOMBIE_DIV > 1) ? $clog2(ZOMBIE_DIV) : 1;
  localparam int HPW = $clog2(ZOMBIE_HP + 1);
  localparam logic [POS_W-1:0] B_STEP    = POS_W'(BULLET_STEP);
  localparam logic [POS_W-1:0] Z_STEP    = POS_W'(ZOMBIE_STEP);
  localparam logic [FW-1:0]    FIRE_LAST = FW'(FIRE_PERIOD - 1);
  localparam logic [ZW-1:0]    ZDIV_LAST = ZW'(ZOMBIE_DIV - 1);
  localparam logic [HPW-1:0]   HP_FULL   = HPW'(ZOMBIE_HP);

  state_e           state_r;
  logic [1:0]       lane_idx_r;
  logic [FW-1:0]    fire_cnt_r;
  logic [ZW-1:0]    zdiv_cnt_r;
  logic [POS_W-1:0] bpos_r [LANES];
  logic [POS_W-1:0] zpos_r [LANES];
  logic [HPW-1:0]   hp_r   [LANES];
  logic [LANES-1:0] bact_r, zact_r;
  logic [7:0]       score_r;
  logic             game_over_r, busy_r, update_done_r;

  logic [7:0]       lfsr_s;
  logic             lfsr_unused_s;
  logic [POS_W-1:0] nb_s, nz_s;
  logic             nba_s, nza_s, kill_s, house_s;
  logic [HPW-1:0]   nhp_s;

  lane_sprite_scheduler_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (state_r == ST_LANE),
    .value (lfsr_s)
  );

  assign lfsr_unused_s = ^lfsr_s[7:3];

  // Shared lane datapath: next bullet/zombie state for the lane selected by lane_idx_r.
  always_comb begin
    nb_s    = bpos_r[lane_idx_r];
    nba_s   = bact_r[lane_idx_r];
    nz_s    = zpos_r[lane_idx_r];
    nza_s   = zact_r[lane_idx_r];
    nhp_s   = hp_r[lane_idx_r];
    kill_s  = 1'b0;
    house_s = 1'b0;

    // A freshly spawned zombie or fired bullet holds still for its first frame.
    if (!zact_r[lane_idx_r] && (spawn_req[lane_idx_r] || int'(lfsr_s[2:0]) < SPAWN_THRESH)) begin
      nza_s = 1'b1;
      nz_s  = {POS_W{1'b0}};
      nhp_s = HP_FULL;
    end else if (zact_r[lane_idx_r] && zdiv_cnt_r == {ZW{1'b0}}) begin
      nz_s = zpos_r[lane_idx_r] + Z_STEP;
    end else begin
      nz_s = zpos_r[lane_idx_r];
    end

    if (plant_en[lane_idx_r] && !bact_r[lane_idx_r] && fire_cnt_r == {FW{1'b0}}) begin
      nba_s = 1'b1;
      nb_s  = {POS_W{1'b0}};
    end else if (bact_r[lane_idx_r]) begin
      nb_s = bpos_r[lane_idx_r] + B_STEP;
    end else begin
      nb_s = bpos_r[lane_idx_r];
    end

    if (nba_s && nza_s && (nb_s + nz_s >= COLLIDE_SUM)) begin
      nba_s = 1'b0;
      nb_s  = {POS_W{1'b0}};
      if (nhp_s <= HPW'(1)) begin
        nza_s  = 1'b0;
        nz_s   = {POS_W{1'b0}};
        nhp_s  = {HPW{1'b0}};
        kill_s = 1'b1;
      end else begin
        nhp_s = nhp_s - HPW'(1);
      end
    end else if (nba_s && nb_s >= EDGE_MAX) begin
      nba_s = 1'b0;
      nb_s  = {POS_W{1'b0}};
    end else begin
      kill_s = 1'b0;
    end

    if (nza_s && nz_s >= EDGE_MAX) begin
      nz_s    = EDGE_MAX;
      house_s = 1'b1;
    end else begin
      house_s = 1'b0;
    end
  end

  // Frame sequencer and all game state; restart clears everything but the LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      lane_idx_r    <= 2'd0;
      fire_cnt_r    <= {FW{1'b0}};
      zdiv_cnt_r    <= {ZW{1'b0}};
      bact_r        <= {LANES{1'b0}};
      zact_r        <= {LANES{1'b0}};
      score_r       <= 8'd0;
      game_over_r   <= 1'b0;
      busy_r        <= 1'b0;
      update_done_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        bpos_r[i] <= {POS_W{1'b0}};
        zpos_r[i] <= {POS_W{1'b0}};
        hp_r[i]   <= {HPW{1'b0}};
      end
    end else if (restart) begin
      state_r       <= ST_IDLE;
      lane_idx_r    <= 2'd0;
      fire_cnt_r    <= {FW{1'b0}};
      zdiv_cnt_r    <= {ZW{1'b0}};
      bact_r        <= {LANES{1'b0}};
      zact_r        <= {LANES{1'b0}};
      score_r       <= 8'd0;
      game_over_r   <= 1'b0;
      busy_r        <= 1'b0;
      update_done_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        bpos_r[i] <= {POS_W{1'b0}};
        zpos_r[i] <= {POS_W{1'b0}};
        hp_r[i]   <= {HPW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          update_done_r <= 1'b0;
          if (frame_tick && !game_over_r) begin
            state_r    <= ST_LANE;
            lane_idx_r <= 2'd0;
            busy_r     <= 1'b1;
          end
        end
        ST_LANE: begin
          bpos_r[lane_idx_r] <= nb_s;
          bact_r[lane_idx_r] <= nba_s;
          zpos_r[lane_idx_r] <= nz_s;
          zact_r[lane_idx_r] <= nza_s;
          hp_r[lane_idx_r]   <= nhp_s;
          if (kill_s) score_r <= sat_inc8(score_r);
          if (house_s) game_over_r <= 1'b1;
          if (lane_idx_r == 2'(LANES - 1)) begin
            state_r       <= ST_DONE;
            update_done_r <= 1'b1;
          end else begin
            lane_idx_r <= lane_idx_r + 2'd1;
          end
        end
        ST_DONE: begin
          fire_cnt_r    <= (fire_cnt_r == FIRE_LAST) ? {FW{1'b0}} : fire_cnt_r + FW'(1);
          zdiv_cnt_r    <= (zdiv_cnt_r == ZDIV_LAST) ? {ZW{1'b0}} : zdiv_cnt_r + ZW'(1);
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          update_done_r <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          update_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bullet_pos  = {bpos_r[3], bpos_r[2], bpos_r[1], bpos_r[0]};
  assign zomb_pos    = {zpos_r[3], zpos_r[2], zpos_r[1], zpos_r[0]};
  assign bullet_act  = bact_r;
  assign zomb_act    = zact_r;
  assign score       = score_r;
  assign game_over   = game_over_r;
  assign busy        = busy_r;
  assign update_done = update_done_r;

endmodule

// File: tb/tb_lane_sprite_scheduler.sv
// Directed bench: a vector table of multi-frame steps plus hand sequences for
// frame timing, mid-update restart, tick overlap, game over and score saturation.
module tb_lane_sprite_scheduler;

  logic        clk = 1'b0;
  logic        rst, frame_tick, restart, sat_restart;
  logic [3:0]  plant_en, spawn_req;
  logic [43:0] bullet_pos, zomb_pos, s_bpos, s_zpos;
  logic [3:0]  bullet_act, zomb_act, s_bact, s_zact;
  logic [7:0]  score, s_score;
  logic        game_over, busy, update_done, s_go, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_sprite_scheduler #(.SPAWN_THRESH(0)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .plant_en(plant_en), .spawn_req(spawn_req),
    .bullet_pos(bullet_pos), .bullet_act(bullet_act),
    .zomb_pos(zomb_pos), .zomb_act(zomb_act),
    .score(score), .game_over(game_over), .busy(busy), .update_done(update_done)
  );

  // Fast-kill configuration: every lane spawns and fires, kills every third frame.
  lane_sprite_scheduler #(.BULLET_STEP(200), .FIRE_PERIOD(1), .ZOMBIE_HP(1),
                          .SPAWN_THRESH(8)) u_sat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(sat_restart),
    .plant_en(4'b1111), .spawn_req(4'b0000),
    .bullet_pos(s_bpos), .bullet_act(s_bact),
    .zomb_pos(s_zpos), .zomb_act(s_zact),
    .score(s_score), .game_over(s_go), .busy(s_busy), .update_done(s_done)
  );

  typedef struct {
    string       name;
    logic        rs;
    logic [3:0]  plant;
    logic [3:0]  spawn;
    int          frames;
    logic [3:0]  e_bact;
    logic [10:0] e_bpos0;
    logic [3:0]  e_zact;
    int          zlane;
    logic [10:0] e_zpos;
    logic [7:0]  e_score;
    logic        e_go;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the frame update complete.
  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.rs) pulse_restart();
    plant_en  = v.plant;
    spawn_req = v.spawn;
    run_frames(v.frames);
    spawn_req = 4'b0000;
    chk({v.name, ".bact"},  64'(bullet_act), 64'(v.e_bact));
    chk({v.name, ".bpos0"}, 64'(bullet_pos[10:0]), 64'(v.e_bpos0));
    chk({v.name, ".zact"},  64'(zomb_act), 64'(v.e_zact));
    chk({v.name, ".zpos"},  64'(zomb_pos[v.zlane*11 +: 11]), 64'(v.e_zpos));
    chk({v.name, ".score"}, 64'(score), 64'(v.e_score));
    chk({v.name, ".go"},    64'(game_over), 64'(v.e_go));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".bpos"}, 64'(bullet_pos), 64'd0);
    chk({name, ".bact"}, 64'(bullet_act), 64'd0);
    chk({name, ".zpos"}, 64'(zomb_pos), 64'd0);
    chk({name, ".zact"}, 64'(zomb_act), 64'd0);
    chk({name, ".score"}, 64'(score), 64'd0);
    chk({name, ".go"}, 64'(game_over), 64'd0);
    chk({name, ".busy"}, 64'(busy), 64'd0);
    chk({name, ".done"}, 64'(update_done), 64'd0);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    //          name         rs    plant    spawn    frm  bact     bpos0    zact     zl  zpos     score  go
    vecs[0]  = '{"bt_fire",   1'b1, 4'b0001, 4'b0000, 1,   4'b0001, 11'd0,   4'b0000, 0, 11'd0,   8'd0, 1'b0};
    vecs[1]  = '{"bt_516",    1'b0, 4'b0001, 4'b0000, 129, 4'b0001, 11'd516, 4'b0000, 0, 11'd0,   8'd0, 1'b0};
    vecs[2]  = '{"bt_clear",  1'b0, 4'b0001, 4'b0000, 1,   4'b0000, 11'd0,   4'b0000, 0, 11'd0,   8'd0, 1'b0};
    vecs[3]  = '{"bt_wait",   1'b0, 4'b0001, 4'b0000, 29,  4'b0000, 11'd0,   4'b0000, 0, 11'd0,   8'd0, 1'b0};
    vecs[4]  = '{"bt_refire", 1'b0, 4'b0001, 4'b0000, 1,   4'b0001, 11'd0,   4'b0000, 0, 11'd0,   8'd0, 1'b0};
    vecs[5]  = '{"co_start",  1'b1, 4'b0001, 4'b0001, 1,   4'b0001, 11'd0,   4'b0001, 0, 11'd0,   8'd0, 1'b0};
    vecs[6]  = '{"co_pre1",   1'b0, 4'b0001, 4'b0000, 63,  4'b0001, 11'd252, 4'b0001, 0, 11'd126, 8'd0, 1'b0};
    vecs[7]  = '{"co_hit1",   1'b0, 4'b0001, 4'b0000, 1,   4'b0000, 11'd0,   4'b0001, 0, 11'd128, 8'd0, 1'b0};
    vecs[8]  = '{"co_refire", 1'b0, 4'b0001, 4'b0000, 32,  4'b0001, 11'd0,   4'b0001, 0, 11'd192, 8'd0, 1'b0};
    vecs[9]  = '{"co_pre2",   1'b0, 4'b0001, 4'b0000, 31,  4'b0001, 11'd124, 4'b0001, 0, 11'd254, 8'd0, 1'b0};
    vecs[10] = '{"co_hit2",   1'b0, 4'b0001, 4'b0000, 1,   4'b0000, 11'd0,   4'b0001, 0, 11'd256, 8'd0, 1'b0};
    vecs[11] = '{"co_pre3",   1'b0, 4'b0001, 4'b0000, 42,  4'b0001, 11'd40,  4'b0001, 0, 11'd340, 8'd0, 1'b0};
    vecs[12] = '{"co_kill",   1'b0, 4'b0001, 4'b0000, 1,   4'b0000, 11'd0,   4'b0000, 0, 11'd0,   8'd1, 1'b0};
    vecs[13] = '{"go_spawn",  1'b1, 4'b0000, 4'b0100, 1,   4'b0000, 11'd0,   4'b0100, 2, 11'd0,   8'd0, 1'b0};
    vecs[14] = '{"go_pre",    1'b0, 4'b0000, 4'b0000, 259, 4'b0000, 11'd0,   4'b0100, 2, 11'd518, 8'd0, 1'b0};
    vecs[15] = '{"go_house",  1'b0, 4'b0000, 4'b0000, 1,   4'b0000, 11'd0,   4'b0100, 2, 11'd520, 8'd0, 1'b1};

    rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; sat_restart = 1'b0;
    plant_en = 4'b0000; spawn_req = 4'b0000;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Idle frame: busy for T+1..T+5, update_done only at T+5.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("idle.busy%0d", c), 64'(busy), 64'(c <= 5));
      chk($sformatf("idle.done%0d", c), 64'(update_done), 64'(c == 5));
      @(negedge clk);
    end
    chk("idle.bpos", 64'(bullet_pos), 64'd0);
    chk("idle.zpos", 64'(zomb_pos), 64'd0);

    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    // Restart at T+2 aborts the update; score 1 must clear, no update_done.
    plant_en = 4'b1111;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_all_zero("rs_mid");
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      done_cnt += int'(update_done);
    end
    chk("rs_mid.nodone", 64'(done_cnt), 64'd0);
    plant_en = 4'b0001;
    run_frames(1);
    chk("rs_mid.fire_cnt0", 64'(bullet_act), 64'd1);

    // Second tick at T+3 arrives while busy and must be dropped.
    pulse_restart();
    plant_en = 4'b0000;
    busy_cnt = 0; done_cnt = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      frame_tick = (c == 3);
      busy_cnt += int'(busy);
      done_cnt += int'(update_done);
    end
    chk("overlap.done", 64'(done_cnt), 64'd1);
    chk("overlap.busy", 64'(busy_cnt), 64'd5);

    for (int i = 13; i < 16; i++) apply_vec(vecs[i]);

    // After game over further ticks are ignored.
    busy_cnt = 0; done_cnt = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      busy_cnt += int'(busy);
      done_cnt += int'(update_done);
    end
    chk("go.nobusy", 64'(busy_cnt), 64'd0);
    chk("go.nodone", 64'(done_cnt), 64'd0);
    chk("go.hold", 64'(zomb_pos[32:22]), 64'd520);

    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);

    // Saturation: four kills every three frames.
    sat_restart = 1'b1;
    @(negedge clk);
    sat_restart = 1'b0;
    @(negedge clk);
    run_frames(189);
    chk("sat.252", 64'(s_score), 64'd252);
    run_frames(3);
    chk("sat.255", 64'(s_score), 64'd255);
    run_frames(6);
    chk("sat.hold", 64'(s_score), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
